// File: rtl/mdu_iter.sv
// Iterative-latency multiply/divide unit holding the HI/LO registers.
// Results are computed at launch, held in pending registers, and committed after a fixed busy count.
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  MDUOp,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        Cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               pwr_q;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        phi_q, plo_q;

  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic [31:0]        a_mag, b_mag, sb_div, ub_div;
  logic [31:0]        sq_mag, sr_mag, sq, sr, uq, ur;
  logic [31:0]        res_hi_d, res_lo_d;
  logic               wr_en_d;
  logic               launch;

  assign launch = (state_q == IDLE) && Start && !Cancel;

  // Signed division is done on magnitudes so that 0x80000000 / -1 wraps
  // to 0x80000000 instead of relying on tool-defined overflow behaviour.
  always_comb begin
    sprod  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    uprod  = {32'd0, A} * {32'd0, B};
    a_mag  = A[31] ? -A : A;
    b_mag  = B[31] ? -B : B;
    sb_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    ub_div = (B == 32'd0) ? 32'd1 : B;
    sq_mag = a_mag / sb_div;
    sr_mag = a_mag % sb_div;
    sq     = (A[31] ^ B[31]) ? -sq_mag : sq_mag;
    sr     = A[31] ? -sr_mag : sr_mag;
    uq     = A / ub_div;
    ur     = A % ub_div;
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    case (MDUOp)
      2'b00:   {res_hi_d, res_lo_d} = sprod;
      2'b01:   {res_hi_d, res_lo_d} = uprod;
      2'b10:   {res_hi_d, res_lo_d} = {sr, sq};
      default: {res_hi_d, res_lo_d} = {ur, uq};
    endcase
    // Divide by zero runs the full latency but never commits.
    wr_en_d = !(MDUOp[1] && (B == 32'd0));
  end

  // Pending result is data only; the commit enable pwr_q gates its use.
  always_ff @(posedge Clk) begin
    if (launch) begin
      phi_q <= res_hi_d;
      plo_q <= res_lo_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pwr_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !Cancel) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= MDUOp[1] ? DIV_LOAD : MULT_LOAD;
            pwr_q   <= wr_en_d;
          end else if (!Cancel) begin
            if (HIWrite) hi_q <= A;
            if (LOWrite) lo_q <= A;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (pwr_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed scenarios plus random operations
// checked against a plain-arithmetic reference of HI/LO.
module tb_mdu_iter;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start, HIWrite, LOWrite, Cancel;
  logic [1:0]  MDUOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  mdu_iter #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDUOp(MDUOp),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .Cancel(Cancel),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] old);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return old;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return old;
        return {(ua % ub) >> 0, 32'd0} | {32'd0, 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; Cancel = 1'b0;
    MDUOp = 2'b00; A = 32'd0; B = 32'd0;
  endtask

  // Called at a negedge with Busy=0; returns at the first negedge with Busy=0 after commit.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic lw, input int inj, input string name);
    int n;
    int lat;
    logic [63:0] e;
    lat = op[1] ? DC : MC;
    e = ref_result(op, a, b, {exp_hi, exp_lo});
    Start = 1'b1; MDUOp = op; A = a; B = b; LOWrite = lw; HIWrite = 1'b0; Cancel = 1'b0;
    @(negedge Clk);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      Start   = (n == inj);
      MDUOp   = (n == inj) ? 2'b10 : $urandom_range(0, 3);
      LOWrite = (n == inj);
      HIWrite = (n == inj);
      Cancel  = (n == inj) ? 1'b0 : 1'($urandom_range(0, 1));
      A = (n == inj) ? 32'hDEAD : $urandom;
      B = $urandom;
      if (n == 0) begin
        total++;
        if (HI !== exp_hi || LO !== exp_lo) begin
          bad++;
          $display("FAIL %s_old_while_busy: got %h_%h expected %h_%h", name, HI, LO, exp_hi, exp_lo);
        end
      end
      n++;
      @(negedge Clk);
    end
    idle_inputs();
    total++;
    if (n != lat) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, n, lat);
    end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    check32({name, "_HI"}, HI, exp_hi);
    check32({name, "_LO"}, LO, exp_lo);
  endtask

  task automatic write_hl(input logic hw, input logic lw, input logic cn,
                          input logic [31:0] a, input string name);
    HIWrite = hw; LOWrite = lw; Cancel = cn; A = a;
    @(negedge Clk);
    idle_inputs();
    if (!cn && hw) exp_hi = a;
    if (!cn && lw) exp_lo = a;
    check32({name, "_HI"}, HI, exp_hi);
    check32({name, "_LO"}, LO, exp_lo);
    check32({name, "_Busy"}, 32'(Busy), 32'd0);
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b0;
    #2;
    check32("reset_HI", HI, 32'd0);
    check32("reset_LO", LO, 32'd0);
    check32("reset_Busy", 32'(Busy), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge Clk);
    check32("post_reset_Busy", 32'(Busy), 32'd0);
  endtask

  task automatic test_mult();
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, -1, "mult_neg");
    check32("mult_neg_HI_const", HI, 32'hFFFFFFFF);
    check32("mult_neg_LO_const", LO, 32'hFFFFFFFA);
    run_op(2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, -1, "multu");
    check32("multu_HI_const", HI, 32'h00000002);
    check32("multu_LO_const", LO, 32'hFFFFFFFA);
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, -1, "div_neg");
    check32("div_neg_LO_const", LO, 32'hFFFFFFFD);
    check32("div_neg_HI_const", HI, 32'hFFFFFFFF);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, -1, "divu_zero");
    check32("divu_zero_HI_kept", HI, 32'hFFFFFFFF);
    check32("divu_zero_LO_kept", LO, 32'hFFFFFFFD);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, "div_ovf");
    check32("div_ovf_LO_const", LO, 32'h80000000);
    check32("div_ovf_HI_const", HI, 32'h00000000);
  endtask

  task automatic test_cancel();
    Start = 1'b1; Cancel = 1'b1; MDUOp = 2'b01; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    idle_inputs();
    check32("cancel_start_Busy", 32'(Busy), 32'd0);
    check32("cancel_start_HI", HI, exp_hi);
    check32("cancel_start_LO", LO, exp_lo);
    @(negedge Clk);
    check32("cancel_start_Busy2", 32'(Busy), 32'd0);
    write_hl(1'b1, 1'b0, 1'b1, 32'h1234, "cancel_mthi");
    write_hl(1'b1, 1'b0, 1'b0, 32'h1234, "mthi");
    check32("mthi_HI_const", HI, 32'h1234);
    write_hl(1'b0, 1'b1, 1'b0, 32'h5678, "mtlo");
    write_hl(1'b1, 1'b1, 1'b0, 32'hCAFE, "mthilo");
  endtask

  task automatic test_back_to_back();
    run_op(2'b00, 32'd2, 32'd3, 1'b0, 1, "mult_ignore");
    check32("mult_ignore_HI_const", HI, 32'd0);
    check32("mult_ignore_LO_const", LO, 32'd6);
    run_op(2'b01, 32'd4, 32'd5, 1'b1, -1, "start_lowrite");
    check32("start_lowrite_LO_const", LO, 32'h14);
  endtask

  task automatic test_async_reset();
    write_hl(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, "pre_reset_fill");
    Start = 1'b1; MDUOp = 2'b10; A = 32'hFFFFFFF9; B = 32'd2;
    @(negedge Clk);
    idle_inputs();
    repeat (5) @(negedge Clk);
    check32("midrun_Busy", 32'(Busy), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check32("async_reset_HI", HI, 32'd0);
    check32("async_reset_LO", LO, 32'd0);
    check32("async_reset_Busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      check32("after_reset_Busy", 32'(Busy), 32'd0);
    end
    check32("after_reset_HI", HI, 32'd0);
    check32("after_reset_LO", LO, 32'd0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0)
        write_hl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, "rand_mt");
      else
        run_op(op, a, b, 1'($urandom_range(0, 1)), -1, "rand_op");
    end
  endtask

  initial begin
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Multi-cycle multiply/divide unit answering the Start/Busy handshake driven by the execute stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu commands and direct HI/LO writes (mthi/mtlo), and holds the HI and LO architectural registers. Busy stays asserted for a fixed latency before results commit. The hazard unit stalls dependent instructions on `Start || Busy`. Interrupt/eret suppression arrives on `Cancel`.

## Interface
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: Busy cycles for div/divu (≥1).
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  launch the operation selected by MDUOp; single-cycle pulse.
- `MDUOp`  in  2  00 mult, 01 multu, 10 div, 11 divu.
- `HIWrite`  in  1  mthi: HI ← A.
- `LOWrite`  in  1  mtlo: LO ← A.
- `Cancel`  in  1  interrupt/eret in the E stage; suppresses Start, HIWrite and LOWrite in the same cycle.
- `A`  in  32  rs operand (forwarded).
- `B`  in  32  rt operand (forwarded).
- `Busy`  out  1  operation in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1. Down-counter `cnt` sized for max(MULT_CYCLES, DIV_CYCLES).
- At a rising edge in IDLE:
  - If `Start && !Cancel`: compute the result from A, B and MDUOp into pending registers pHI/pLO. Load `cnt` with MULT_CYCLES-1 or DIV_CYCLES-1. Go to RUN.
  - Else, if `HIWrite && !Cancel`: HI ← A.
  - Else, if `LOWrite && !Cancel`: LO ← A. HIWrite and LOWrite together write both.
  - Start has priority. HIWrite/LOWrite in the Start cycle are ignored.
- At a rising edge in RUN:
  - If `cnt==0`: {HI,LO} ← {pHI,pLO} and go to IDLE.
  - Else: `cnt` decrements.
  - Start, HIWrite, LOWrite and Cancel are ignored; the in-flight operation always completes.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit A×B.
  - multu: {HI,LO} = unsigned 64-bit A×B.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of A.
  - divu: unsigned quotient to LO, unsigned remainder to HI.
- Boundary cases:
  - Divide by zero (B==0, div or divu): the operation runs the full latency, but HI and LO are left unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Operands are captured at the Start edge. Later changes on A/B have no effect.
- Reset (Reset=0, asynchronous, any state): HI=0, LO=0, Busy=0, state IDLE, cnt=0. Pending results are discarded.

## Timing
- HI, LO and Busy are registered outputs. Nothing combinational runs from inputs to outputs.
- Start is sampled at edge t0. Busy is high in cycles t0+1 … t0+N, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new value at edge t0+N, the same edge at which Busy falls.
- Back-to-back operation: a new Start is accepted in the first cycle with Busy=0, so reissue is possible at t0+N.
- mthi/mtlo effect is visible on HI/LO one cycle after the accepting edge.
- Reading HI/LO while Busy returns the old value. The hazard unit is responsible for stalling mfhi/mflo.
- Cancel asserted with Start: no state change, Busy stays 0.

## Test plan
- Reset low mid-RUN of div (cnt=4) → HI=LO=0 and Busy=0 immediately (asynchronous). After release, Busy stays 0.
- mult A=0xFFFFFFFE (−2), B=3, then multu with the same operands:
  - mult: Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu: HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → Busy for 10 cycles, HI/LO unchanged.
- Start with Cancel=1, and HIWrite with Cancel=1 (A=0x1234) → Busy stays 0, HI/LO unchanged. Same HIWrite with Cancel=0 → HI=0x1234 next cycle.
- During RUN of mult (A=2, B=3), pulse Start (div) and LOWrite (A=0xDEAD) → both ignored. Commit gives HI=0, LO=6. Busy falls at t0+5, and a Start at that cycle is accepted.
- Start together with LOWrite, A=4, B=5, multu → LOWrite ignored. Commit gives LO=0x14.
